serial_twos_complement: RTL and testbench

Multi-cycle, bit-serial two's-complement negate/absolute-value unit built from a single half-adder cell using the invert-plus-one rule. One cell is reused LSB-first over WIDTH cycles instead of a WIDTH-cell ripple chain. Sits on the operand path ahead of the arithmetic datapath and exchanges words through valid/ready handshakes on both sides. Also flags the most-negative-value overflow case.

---
 rtl/stc_pkg.sv | 31 +++
 rtl/stc_bit_cell.sv | 15 +
 rtl/serial_twos_complement.sv | 134 +++++++++++++
 tb/tb_serial_twos_complement.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/stc_pkg.sv
// Shared types and helpers for the bit-serial two's-complement unit.
package stc_pkg;

    // Operation select carried on in_op.
    typedef enum logic [1:0] {
        STC_PASS = 2'b00,
        STC_NEG  = 2'b01,
        STC_ABS  = 2'b10,
        STC_RSVD = 2'b11
    } stc_op_e;

    // Control states: accept, shift WIDTH bits LSB-first, present result.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } stc_state_e;

    // Widest operand the helper below can describe.
    localparam int STC_MAX_WIDTH = 64;

    // Most-negative two's-complement value of width w: only the sign bit set.
    // Callers truncate the result to their own operand width.
    function automatic logic [STC_MAX_WIDTH-1:0] stc_most_neg(input int w);
        logic [STC_MAX_WIDTH-1:0] v;
        v = '0;
        v[w-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/stc_bit_cell.sv
// Single half-adder cell reused once per bit by the serial negate unit.
module stc_bit_cell (
    input  logic a,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and carry of the two input bits.
    always_comb begin
        s    = a ^ cin;
        cout = a & cin;
    end

endmodule

// File: rtl/serial_twos_complement.sv
// Bit-serial negate / absolute-value unit. The operand is shifted out LSB-first
// through one half-adder cell applying invert-plus-one; the result is shifted
// into a register from the MSB side so it is aligned after WIDTH cycles.
//
// Handshakes: a word moves on either port only at a rising edge where both
// valid and ready are high. The unit accepts one operand in IDLE and then holds
// in_ready low until its result has been taken in DONE; out_valid is high only
// in DONE, and out_data/out_ovf stay constant while it waits for out_ready.
module serial_twos_complement
    import stc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(stc_most_neg(WIDTH));

    // state_q is kept as a plain register so checkers can bind to it.
    stc_state_e       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             inv_q, inv_d;
    logic             ovf_q, ovf_d;

    stc_op_e          op;
    logic             op_inv;
    logic             cell_a, cell_cin, cell_s, cell_c;

    // Decode whether the incoming operand gets inverted-plus-one.
    always_comb begin
        op     = stc_op_e'(in_op);
        op_inv = (op == STC_NEG) | ((op == STC_ABS) & in_data[WIDTH-1]);
    end

    // Cell inputs: inverted operand bit and the +1 carry, gated off for PASS.
    always_comb begin
        cell_a   = sreg_q[0] ^ inv_q;
        cell_cin = carry_q & inv_q;
    end

    stc_bit_cell u_cell (
        .a    (cell_a),
        .cin  (cell_cin),
        .s    (cell_s),
        .cout (cell_c)
    );

    // Next-state and datapath updates for accept, shift and result hand-off.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        inv_d   = inv_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sreg_d  = in_data;
                    cnt_d   = '0;
                    carry_d = 1'b1;
                    inv_d   = op_inv;
                    ovf_d   = op_inv & (in_data == MOST_NEG);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Final carry out of the MSB is dropped: result wraps mod 2^WIDTH.
                res_d   = {cell_s, res_q[WIDTH-1:1]};
                sreg_d  = {1'b0, sreg_q[WIDTH-1:1]};
                carry_d = cell_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            inv_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            inv_q   <= inv_d;
            ovf_q   <= ovf_d;
        end
    end

    // Port outputs; in_ready is forced low while reset is held.
    always_comb begin
        in_ready  = rst_n & (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        out_data  = res_q;
        out_ovf   = ovf_q & (state_q == ST_DONE);
        busy      = (state_q == ST_SHIFT) | (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_serial_twos_complement.sv
// Directed and swept checks of serial_twos_complement against a word-level model.
module tb_serial_twos_complement;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [1:0]   in_op = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_ovf;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  // {ovf, data} expected for each accepted operand, in order
  logic [W:0] exp_q[$];

  serial_twos_complement #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // word-level reference: negate is 0 - d, applied for NEG or negative ABS
  function automatic logic [W:0] model(input logic [1:0] op, input logic [W-1:0] d);
    logic         inv;
    logic [W-1:0] r;
    logic [W-1:0] zero;
    zero = '0;
    inv  = (op == 2'b01) || (op == 2'b10 && d[W-1]);
    r    = inv ? (zero - d) : d;
    return {inv && (d == 8'h80), r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one operand from a negedge; returns just after the accepting edge
  task automatic send(input logic [1:0] op, input logic [W-1:0] d, input bit push);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("send_in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    if (push) exp_q.push_back(model(op, d));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // wait (bounded) for out_valid; n = edges since accept. Ends at a negedge.
  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!out_valid && n < 40);
    check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // scoreboard pop and compare at the current negedge
  task automatic score(input string tag);
    logic [W:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, 32'(out_data), 32'(e[W-1:0]));
      check({tag, "_ovf"}, 32'(out_ovf), 32'(e[W]));
    end
  endtask

  // full transaction: optional latency check, stall cycles of backpressure
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] d,
                        input bit chk_lat, input int stall);
    int n;
    out_ready = (stall == 0);
    send(op, d, 1'b1);
    wait_out(n);
    if (chk_lat) check({tag, "_latency"}, 32'(n), 32'(W));
    score(tag);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    if (chk_lat) begin
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    int n;
    int stride;
    int off;
    logic [W-1:0] v;

    // reset state
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // directed operations
    run_op("neg_05", 2'b01, 8'h05, 1'b1, 0);
    run_op("abs_f6", 2'b10, 8'hF6, 1'b1, 0);
    run_op("abs_0a", 2'b10, 8'h0A, 1'b1, 0);
    run_op("pass_3c", 2'b00, 8'h3C, 1'b1, 0);
    run_op("rsvd_3c", 2'b11, 8'h3C, 1'b1, 0);
    run_op("neg_80", 2'b01, 8'h80, 1'b1, 0);
    run_op("abs_80", 2'b10, 8'h80, 1'b1, 0);
    run_op("neg_00", 2'b01, 8'h00, 1'b1, 0);
    run_op("pass_80", 2'b00, 8'h80, 1'b0, 0);

    // backpressure with a stray operand offered while busy
    out_ready = 1'b0;
    send(2'b01, 8'h01, 1'b1);
    wait_out(n);
    check("bp_latency", 32'(n), 32'(W));
    for (int s = 0; s < 5; s++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'hFF);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      in_valid = (s == 2);
      in_data  = 8'h22;
      in_op    = 2'b01;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_valid_end", 32'(out_valid), 32'd1);
    score("bp");
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_exit_valid", 32'(out_valid), 32'd0);
    check("bp_exit_in_ready", 32'(in_ready), 32'd1);
    check("bp_exit_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("bp_stray_not_taken", 32'(busy), 32'd0);

    // asynchronous reset in the middle of a shift
    send(2'b01, 8'h55, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_data", 32'(out_data), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_held_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_abort_neg_02", 2'b01, 8'h02, 1'b1, 0);

    // sweep all values under each op in a random order with random stalls
    for (int op = 0; op < 3; op++) begin
      stride = 2 * $urandom_range(0, 127) + 1;
      off    = $urandom_range(0, 255);
      for (int i = 0; i < 256; i++) begin
        v = 8'((i * stride + off) % 256);
        run_op("sweep", 2'(op), v, 1'b0, $urandom_range(0, 2));
      end
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
